// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the D2/X1/M1/W1 stall and flush sequencer:
// FSM encoding, stage indices and the stall-chain / bubble helpers.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int STG_D2          = 0;
    localparam int STG_X1          = 1;
    localparam int STG_M1          = 2;
    localparam int STG_W1          = 3;
    localparam int NUM_STAGES      = 4;
    localparam int FLUSH_CNT_WIDTH = 4;

    // A stall in any stage holds every older stage behind it.
    function automatic logic [NUM_STAGES-1:0] stall_chain(input logic [NUM_STAGES-1:0] req);
        logic [NUM_STAGES-1:0] s;
        s[STG_W1] = req[STG_W1];
        s[STG_M1] = req[STG_M1] | s[STG_W1];
        s[STG_X1] = req[STG_X1] | s[STG_M1];
        s[STG_D2] = req[STG_D2] | s[STG_X1];
        return s;
    endfunction

    // A stage that moves while its producer holds receives a bubble.
    function automatic logic [NUM_STAGES-1:0] bubble_mask(input logic [NUM_STAGES-1:0] s);
        logic [NUM_STAGES-1:0] f;
        f[STG_D2] = 1'b0;
        f[STG_X1] = s[STG_D2] & ~s[STG_X1];
        f[STG_M1] = s[STG_X1] & ~s[STG_M1];
        f[STG_W1] = s[STG_M1] & ~s[STG_W1];
        return f;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/control bundle between the pipeline stages and the stall sequencer.
interface pipe_stall_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 D2_StallReq;
    logic                 X1_StallReq;
    logic                 M1_StallReq;
    logic                 W1_StallReq;
    logic                 W1_Exception;
    logic                 W1_Eret;
    logic                 PerfClear;
    logic                 D2_Stall;
    logic                 X1_Stall;
    logic                 M1_Stall;
    logic                 W1_Stall;
    logic                 D2_Flush;
    logic                 X1_Flush;
    logic                 M1_Flush;
    logic                 W1_Flush;
    logic                 PC_Redirect;
    logic                 Flushing;
    logic [CNT_WIDTH-1:0] StallCycles;
    logic                 StallTimeout;

    modport master (
        output D2_StallReq, X1_StallReq, M1_StallReq, W1_StallReq,
               W1_Exception, W1_Eret, PerfClear,
        input  D2_Stall, X1_Stall, M1_Stall, W1_Stall,
               D2_Flush, X1_Flush, M1_Flush, W1_Flush,
               PC_Redirect, Flushing, StallCycles, StallTimeout
    );

    modport slave (
        input  D2_StallReq, X1_StallReq, M1_StallReq, W1_StallReq,
               W1_Exception, W1_Eret, PerfClear,
        output D2_Stall, X1_Stall, M1_Stall, W1_Stall,
               D2_Flush, X1_Flush, M1_Flush, W1_Flush,
               PC_Redirect, Flushing, StallCycles, StallTimeout
    );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: backward stall chain, forward bubbles, exception
// flush FSM, stall-cycle performance counter and stuck-stall watchdog.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_WIDTH     = 32
) (
    input  logic              clock,
    input  logic              reset,
    pipe_stall_ctrl_if.slave  bus
);

    localparam int RUN_WIDTH = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_LOAD = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [RUN_WIDTH-1:0]       RUN_LIMIT  = RUN_WIDTH'(STALL_TIMEOUT - 1);
    localparam logic                       GO_FLUSH   = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;

    state_e                     state_q, state_d;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                       timeout_q, timeout_d;
    logic [NUM_STAGES-1:0]      req_s, chain_s, stall_s, flush_s;
    logic                       commit_s, redirect_s, flushing_s, run_stalled_s;
    logic [RUN_WIDTH-1:0]       stall_run_s;
    logic [CNT_WIDTH-1:0]       stall_cycles_s;

    // Gather stage requests and resolve the commit condition.
    always_comb begin
        req_s           = '0;
        req_s[STG_D2]   = bus.D2_StallReq;
        req_s[STG_X1]   = bus.X1_StallReq;
        req_s[STG_M1]   = bus.M1_StallReq;
        req_s[STG_W1]   = bus.W1_StallReq;
        chain_s         = stall_chain(req_s);
        commit_s        = (state_q == ST_RUN) & (bus.W1_Exception | bus.W1_Eret) & ~bus.W1_StallReq;
    end

    // State, flush counter and sticky watchdog registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic for the flush sequence.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (commit_s) begin
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = GO_FLUSH ? ST_FLUSH : ST_RUN;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q - FLUSH_CNT_WIDTH'(1);
                if (flush_cnt_q == FLUSH_CNT_WIDTH'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Stage controls; reset forces every stage to take a bubble.
    always_comb begin
        stall_s    = '0;
        flush_s    = '0;
        redirect_s = 1'b0;
        flushing_s = 1'b0;
        if (reset) begin
            flush_s = '1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (commit_s) begin
                        flush_s    = '1;
                        redirect_s = 1'b1;
                    end else begin
                        stall_s = chain_s;
                        flush_s = bubble_mask(chain_s);
                    end
                end
                ST_FLUSH: begin
                    flush_s    = '1;
                    flushing_s = 1'b1;
                end
                default: begin
                    flush_s = '1;
                end
            endcase
        end
    end

    // Watchdog: >= keeps it able to re-fire if cleared mid-stall.
    always_comb begin
        run_stalled_s = (state_q == ST_RUN) & stall_s[STG_D2];
        if (bus.PerfClear) begin
            timeout_d = 1'b0;
        end else if (run_stalled_s && (stall_run_s >= RUN_LIMIT)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cycles (
        .clk_i (clock),
        .rst_i (reset),
        .clr_i (bus.PerfClear),
        .inc_i (run_stalled_s),
        .cnt_o (stall_cycles_s)
    );

    sat_counter #(.WIDTH(RUN_WIDTH)) u_stall_run (
        .clk_i (clock),
        .rst_i (reset),
        .clr_i (~run_stalled_s),
        .inc_i (run_stalled_s),
        .cnt_o (stall_run_s)
    );

    assign bus.D2_Stall     = stall_s[STG_D2];
    assign bus.X1_Stall     = stall_s[STG_X1];
    assign bus.M1_Stall     = stall_s[STG_M1];
    assign bus.W1_Stall     = stall_s[STG_W1];
    assign bus.D2_Flush     = flush_s[STG_D2];
    assign bus.X1_Flush     = flush_s[STG_X1];
    assign bus.M1_Flush     = flush_s[STG_M1];
    assign bus.W1_Flush     = flush_s[STG_W1];
    assign bus.PC_Redirect  = redirect_s;
    assign bus.Flushing     = flushing_s;
    assign bus.StallCycles  = stall_cycles_s;
    assign bus.StallTimeout = timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench: instance A (3-cycle flush, 32-bit counter) and instance B
// (single-cycle flush, 2-bit counter to exercise saturation) share stimulus.
module tb_pipe_stall_ctrl;

    logic clock = 1'b0;
    logic reset;
    logic d2r, x1r, m1r, w1r, exc, eret, pclr;
    int   total  = 0;
    int   passed = 0;

    always #5 clock = ~clock;

    pipe_stall_ctrl_if #(.CNT_WIDTH(32)) if_a ();
    pipe_stall_ctrl_if #(.CNT_WIDTH(2))  if_b ();

    assign if_a.D2_StallReq = d2r;   assign if_b.D2_StallReq = d2r;
    assign if_a.X1_StallReq = x1r;   assign if_b.X1_StallReq = x1r;
    assign if_a.M1_StallReq = m1r;   assign if_b.M1_StallReq = m1r;
    assign if_a.W1_StallReq = w1r;   assign if_b.W1_StallReq = w1r;
    assign if_a.W1_Exception = exc;  assign if_b.W1_Exception = exc;
    assign if_a.W1_Eret = eret;      assign if_b.W1_Eret = eret;
    assign if_a.PerfClear = pclr;    assign if_b.PerfClear = pclr;

    pipe_stall_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(8), .CNT_WIDTH(32)) dut_a (
        .clock (clock), .reset (reset), .bus (if_a.slave)
    );
    pipe_stall_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(8), .CNT_WIDTH(2)) dut_b (
        .clock (clock), .reset (reset), .bus (if_b.slave)
    );

    // Vectors ordered {D2, X1, M1, W1}.
    wire [3:0] st_a = {if_a.D2_Stall, if_a.X1_Stall, if_a.M1_Stall, if_a.W1_Stall};
    wire [3:0] fl_a = {if_a.D2_Flush, if_a.X1_Flush, if_a.M1_Flush, if_a.W1_Flush};
    wire [3:0] st_b = {if_b.D2_Stall, if_b.X1_Stall, if_b.M1_Stall, if_b.W1_Stall};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {d2r, x1r, m1r, w1r, exc, eret, pclr} = 7'b0;
        #1;
        chk("rst_flush", {28'd0, fl_a}, 32'hF);
        chk("rst_stall", {28'd0, st_a}, 32'h0);
        chk("rst_flushing", {31'd0, if_a.Flushing}, 32'd0);
        chk("rst_redirect", {31'd0, if_a.PC_Redirect}, 32'd0);
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk("idle_stall", {28'd0, st_a}, 32'h0);
        chk("idle_flush", {28'd0, fl_a}, 32'h0);
        chk("idle_cycles", if_a.StallCycles, 32'd0);
        chk("idle_cycles_b", {30'd0, if_b.StallCycles}, 32'd0);
        chk("idle_timeout", {31'd0, if_a.StallTimeout}, 32'd0);

        // M1 stall for three cycles
        m1r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("m1_stall", {28'd0, st_a}, 32'hE);
            chk("m1_flush", {28'd0, fl_a}, 32'h1);
            tick();
        end
        m1r = 1'b0;
        #1;
        chk("m1_release_stall", {28'd0, st_a}, 32'h0);
        chk("m1_release_flush", {28'd0, fl_a}, 32'h0);
        chk("m1_cycles", if_a.StallCycles, 32'd3);
        chk("m1_cycles_b", {30'd0, if_b.StallCycles}, 32'd3);

        // D2 stall for one cycle; B counter is already saturated
        d2r = 1'b1;
        #1;
        chk("d2_stall", {28'd0, st_a}, 32'h8);
        chk("d2_flush", {28'd0, fl_a}, 32'h4);
        tick();
        d2r = 1'b0;
        #1;
        chk("d2_release", {28'd0, st_a}, 32'h0);
        chk("d2_cycles", if_a.StallCycles, 32'd4);
        chk("sat_b", {30'd0, if_b.StallCycles}, 32'd3);

        // Exception commit: A flushes 3 cycles, B returns to RUN at once
        exc = 1'b1;
        #1;
        chk("exc_redirect", {31'd0, if_a.PC_Redirect}, 32'd1);
        chk("exc_flush", {28'd0, fl_a}, 32'hF);
        chk("exc_stall", {28'd0, st_a}, 32'h0);
        chk("exc_flushing", {31'd0, if_a.Flushing}, 32'd0);
        tick();
        exc = 1'b0;
        m1r = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("fl_flushing", {31'd0, if_a.Flushing}, 32'd1);
            chk("fl_flush", {28'd0, fl_a}, 32'hF);
            chk("fl_stall_ignored", {28'd0, st_a}, 32'h0);
            chk("fl_redirect", {31'd0, if_a.PC_Redirect}, 32'd0);
            chk("b_flushing", {31'd0, if_b.Flushing}, 32'd0);
            chk("b_stall", {28'd0, st_b}, 32'hE);
            tick();
        end
        m1r = 1'b0;
        #1;
        chk("fl_done_flushing", {31'd0, if_a.Flushing}, 32'd0);
        chk("fl_done_flush", {28'd0, fl_a}, 32'h0);
        chk("fl_cycles", if_a.StallCycles, 32'd4);

        // Commit blocked by W1 hold for two cycles
        exc = 1'b1;
        w1r = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("blk_redirect", {31'd0, if_a.PC_Redirect}, 32'd0);
            chk("blk_stall", {28'd0, st_a}, 32'hF);
            chk("blk_flush", {28'd0, fl_a}, 32'h0);
            tick();
        end
        w1r = 1'b0;
        #1;
        chk("blk_commit_redirect", {31'd0, if_a.PC_Redirect}, 32'd1);
        chk("blk_commit_flush", {28'd0, fl_a}, 32'hF);
        tick();
        exc = 1'b0;
        #1;
        chk("blk_flushing", {31'd0, if_a.Flushing}, 32'd1);
        chk("blk_no_redirect", {31'd0, if_a.PC_Redirect}, 32'd0);
        tick();
        tick();
        #1;
        chk("blk_run", {31'd0, if_a.Flushing}, 32'd0);
        chk("blk_cycles", if_a.StallCycles, 32'd6);

        // Watchdog: X1 stall held ten cycles
        x1r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("wd_stall", {28'd0, st_a}, 32'hC);
            chk("wd_flush", {28'd0, fl_a}, 32'h2);
            chk("wd_timeout", {31'd0, if_a.StallTimeout}, (i >= 8) ? 32'd1 : 32'd0);
            tick();
        end
        x1r = 1'b0;
        #1;
        chk("wd_sticky", {31'd0, if_a.StallTimeout}, 32'd1);
        chk("wd_cycles", if_a.StallCycles, 32'd16);
        tick();
        tick();
        #1;
        chk("wd_sticky_idle", {31'd0, if_a.StallTimeout}, 32'd1);
        pclr = 1'b1;
        x1r = 1'b1;
        #1;
        chk("clr_pending", {31'd0, if_a.StallTimeout}, 32'd1);
        tick();
        pclr = 1'b0;
        x1r = 1'b0;
        #1;
        chk("clr_timeout", {31'd0, if_a.StallTimeout}, 32'd0);
        chk("clr_cycles", if_a.StallCycles, 32'd0);
        chk("clr_cycles_b", {30'd0, if_b.StallCycles}, 32'd0);

        // Simultaneous exception and ERET, then reset mid-flush
        exc = 1'b1;
        eret = 1'b1;
        #1;
        chk("both_redirect", {31'd0, if_a.PC_Redirect}, 32'd1);
        tick();
        exc = 1'b0;
        eret = 1'b0;
        #1;
        chk("both_flushing", {31'd0, if_a.Flushing}, 32'd1);
        chk("both_single_redirect", {31'd0, if_a.PC_Redirect}, 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_flushing", {31'd0, if_a.Flushing}, 32'd0);
        chk("midrst_flush", {28'd0, fl_a}, 32'hF);
        chk("midrst_stall", {28'd0, st_a}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_flushing", {31'd0, if_a.Flushing}, 32'd0);
        chk("post_rst_flush", {28'd0, fl_a}, 32'h0);
        chk("post_rst_redirect", {31'd0, if_a.PC_Redirect}, 32'd0);
        m1r = 1'b1;
        #1;
        chk("post_rst_stall", {28'd0, st_a}, 32'hE);
        tick();
        m1r = 1'b0;
        #1;
        chk("post_rst_cycles", if_a.StallCycles, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
